// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding and retry
// counter width. Optional feature macro: PLL_BYPASS_FALLBACK_EN adds BYPASS.
package pll_reset_sequencer_pkg;

  localparam int RETRY_W = 2;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
`ifdef PLL_BYPASS_FALLBACK_EN
    , BYPASS  = 3'd5
`endif
  } state_e;

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer with async active-high reset to 0.
// Generic; usable for any asynchronous board input.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; only sync_q is safe to consume.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: drives iCE40 PLL RESETB/BYPASS from the 12 MHz reference,
// qualifies LOCK and holds sys_rst until lock has been stable, with timeout,
// bounded retry and lock-loss recovery.
// Optional feature macro: PLL_BYPASS_FALLBACK_EN (final failure enters BYPASS
// instead of FAULT and runs the design on the reference clock).
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int RESET_CYCLES  = 12,
  parameter int LOCK_TIMEOUT  = 1200,
  parameter int STABLE_CYCLES = 120,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 16
) (
  input  logic               clk_12MHz,
  input  logic               rst,
  input  logic               restart_req,
  input  logic               pll_lock,
  output logic               pll_resetb,
  output logic               pll_bypass,
  output logic               sys_rst,
  output logic               ready,
  output logic               fault,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic               lost_q, lost_d;
  logic               sys_rst_q, sys_rst_d;
  logic               fail;
  logic               lock_s;

  sync_2ff u_lock_sync (
    .clk_i (clk_12MHz),
    .rst_i (rst),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

  assign cnt_inc   = (cnt_q == '1)   ? cnt_q   : cnt_q + CNT_W'(1);
  assign retry_inc = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);

  // Next-state logic; restart_req is applied last so it overrides everything.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    fail    = 1'b0;
    case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s)                  state_d = STABLE;
        else if (cnt_q == LOCK_LAST) fail    = 1'b1;
      end
      STABLE: begin
        if (!lock_s)                 fail    = 1'b1;
        else if (cnt_q == STAB_LAST) state_d = RUN;
      end
      RUN: begin
        // Lock loss in RUN is recovered, not counted as a failed attempt.
        if (!lock_s) begin
          lost_d  = 1'b1;
          retry_d = '0;
          state_d = PLL_RST;
        end
      end
      FAULT: ;
`ifdef PLL_BYPASS_FALLBACK_EN
      BYPASS: ;
`endif
      default: state_d = PLL_RST;
    endcase

    if (fail) begin
      retry_d = retry_inc;
      if (retry_inc == RETRY_MAX) begin
`ifdef PLL_BYPASS_FALLBACK_EN
        state_d = BYPASS;
`else
        state_d = FAULT;
`endif
      end else begin
        state_d = PLL_RST;
      end
    end

    if (restart_req) begin
      state_d = PLL_RST;
      retry_d = '0;
      lost_d  = 1'b0;
    end

    // A restart into PLL_RST from PLL_RST is not a state change but still restarts the count.
    cnt_d = (state_d != state_q || restart_req) ? '0 : cnt_inc;

    // sys_rst is registered from the next state so it drops on the edge entering RUN.
`ifdef PLL_BYPASS_FALLBACK_EN
    sys_rst_d = !(state_d == RUN || state_d == BYPASS);
`else
    sys_rst_d = (state_d != RUN);
`endif
  end

  // Sequencer state, phase counter, retry count, sticky lock-loss flag and sys_rst.
  always_ff @(posedge clk_12MHz or posedge rst) begin
    if (rst) begin
      state_q   <= PLL_RST;
      cnt_q     <= '0;
      retry_q   <= '0;
      lost_q    <= 1'b0;
      sys_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      lost_q    <= lost_d;
      sys_rst_q <= sys_rst_d;
    end
  end

  // PLL is only released from reset while an attempt is running or locked.
  assign pll_resetb = (state_q == WAIT_LOCK) || (state_q == STABLE) || (state_q == RUN);
  assign sys_rst    = sys_rst_q;
  assign lock_lost  = lost_q;
  assign retry_cnt  = retry_q;

`ifdef PLL_BYPASS_FALLBACK_EN
  assign pll_bypass = (state_q == BYPASS);
  assign ready      = (state_q == RUN)   || (state_q == BYPASS);
  assign fault      = (state_q == FAULT) || (state_q == BYPASS);
`else
  assign pll_bypass = 1'b0;
  assign ready      = (state_q == RUN);
  assign fault      = (state_q == FAULT);
`endif

endmodule
